// File: rtl/i2s_tx_master.sv
// ---------------------------------------------------------------------------
// i2s_tx_master
//   I2S transmitter acting as clock master. Accepts 24-bit left/right sample
//   pairs over a valid/ready handshake into a one-pair holding buffer. It
//   generates I2S_sclk, I2S_ws and I2S_data from the system clock. Each pair
//   is loaded into the channel shift registers at the start of a frame
//   (bcnt = 0). It is sent MSB first with the standard one-bit I2S delay
//   after the ws edge.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous active-low reset
//   lft_smpl   in   left sample, two's complement, WIDTH bits
//   rght_smpl  in   right sample, two's complement, WIDTH bits
//   smpl_vld   in   sample pair valid
//   smpl_rdy   out  holding buffer empty; pair taken when smpl_vld & smpl_rdy
//   I2S_sclk   out  bit clock, period 2*SCLK_DIV clk
//   I2S_ws     out  word select, 0 = left, 1 = right
//   I2S_data   out  serial data, changes on sclk fall
//   frame_strt out  one-clk pulse at every frame load
//   underrun   out  one-clk pulse when a frame loads with no data available
//
// Optional feature (macro I2S_TX_REPEAT_EN):
//   When defined, an underrun frame retransmits the last pair that was sent
//   instead of zeros. The last-pair register only exists in that build.
// ---------------------------------------------------------------------------
module i2s_tx_master #(
  parameter int SCLK_DIV  = 16,
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lft_smpl,
  input  logic [WIDTH-1:0] rght_smpl,
  input  logic             smpl_vld,
  output logic             smpl_rdy,
  output logic             I2S_sclk,
  output logic             I2S_ws,
  output logic             I2S_data,
  output logic             frame_strt,
  output logic             underrun
);

  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BCNT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(2 * SLOT_BITS - 1);
  localparam logic [BCNT_W-1:0] SLOT_LEN  = BCNT_W'(SLOT_BITS);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(WIDTH);

  // A slot must hold the delay bit plus every data bit.
  generate
    if (SLOT_BITS < WIDTH + 1) begin : g_bad_slot
      $error("i2s_tx_master: SLOT_BITS must be at least WIDTH+1");
    end
  endgenerate

  logic [DIV_W-1:0]  div_q,      div_d;
  logic              sclk_q,     sclk_d;
  logic              ws_q,       ws_d;
  logic              data_q,     data_d;
  logic [BCNT_W-1:0] bcnt_q,     bcnt_d;
  logic              buf_full_q, buf_full_d;
  logic [WIDTH-1:0]  buf_l_q,    buf_l_d;
  logic [WIDTH-1:0]  buf_r_q,    buf_r_d;
  logic [WIDTH-1:0]  sh_l_q,     sh_l_d;
  logic [WIDTH-1:0]  sh_r_q,     sh_r_d;
  logic              smpl_rdy_q, smpl_rdy_d;
  logic              frame_strt_q, frame_strt_d;
  logic              underrun_q, underrun_d;
`ifdef I2S_TX_REPEAT_EN
  logic [WIDTH-1:0]  last_l_q,   last_l_d;
  logic [WIDTH-1:0]  last_r_q,   last_r_d;
`endif

  logic              div_wrap_s;
  logic              fall_tick_s;
  logic              right_slot_s;
  logic [BCNT_W-1:0] pos_s;
  logic              load_s;
  logic              accept_s;

  // Next-state logic: clock divider, bit counter, serializer, buffer/handshake.
  always_comb begin
    div_wrap_s   = (div_q == DIV_LAST);
    fall_tick_s  = div_wrap_s && sclk_q;
    right_slot_s = (bcnt_q >= SLOT_LEN);
    pos_s        = right_slot_s ? (bcnt_q - SLOT_LEN) : bcnt_q;
    load_s       = fall_tick_s && (bcnt_q == {BCNT_W{1'b0}});
    accept_s     = smpl_vld && smpl_rdy_q;

    div_d        = div_q;
    sclk_d       = sclk_q;
    ws_d         = ws_q;
    data_d       = data_q;
    bcnt_d       = bcnt_q;
    buf_full_d   = buf_full_q;
    buf_l_d      = buf_l_q;
    buf_r_d      = buf_r_q;
    sh_l_d       = sh_l_q;
    sh_r_d       = sh_r_q;
    frame_strt_d = 1'b0;
    underrun_d   = 1'b0;
`ifdef I2S_TX_REPEAT_EN
    last_l_d     = last_l_q;
    last_r_d     = last_r_q;
`endif

    if (div_wrap_s) begin
      div_d  = {DIV_W{1'b0}};
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
      sclk_d = sclk_q;
    end

    if (fall_tick_s) begin
      bcnt_d = (bcnt_q == BCNT_LAST) ? {BCNT_W{1'b0}} : (bcnt_q + BCNT_W'(1));
      // ws leads the slot's data by one bit: it flips at p = 0.
      ws_d   = right_slot_s;
      if (pos_s == {BCNT_W{1'b0}}) begin
        data_d = 1'b0;
      end else if (pos_s <= DATA_LAST) begin
        if (right_slot_s) begin
          data_d = sh_r_q[WIDTH-1];
          sh_r_d = {sh_r_q[WIDTH-2:0], 1'b0};
        end else begin
          data_d = sh_l_q[WIDTH-1];
          sh_l_d = {sh_l_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        data_d = 1'b0;
      end
    end else begin
      bcnt_d = bcnt_q;
    end

    if (load_s) begin
      frame_strt_d = 1'b1;
      if (buf_full_q) begin
        sh_l_d     = buf_l_q;
        sh_r_d     = buf_r_q;
        buf_full_d = 1'b0;
      end else if (smpl_vld) begin
        // Empty buffer but a pair is offered right now: send it this frame.
        sh_l_d = lft_smpl;
        sh_r_d = rght_smpl;
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_TX_REPEAT_EN
        sh_l_d = last_l_q;
        sh_r_d = last_r_q;
`else
        sh_l_d = {WIDTH{1'b0}};
        sh_r_d = {WIDTH{1'b0}};
`endif
      end
`ifdef I2S_TX_REPEAT_EN
      last_l_d = sh_l_d;
      last_r_d = sh_r_d;
`endif
    end else if (accept_s) begin
      buf_l_d    = lft_smpl;
      buf_r_d    = rght_smpl;
      buf_full_d = 1'b1;
    end else begin
      buf_full_d = buf_full_q;
    end

    smpl_rdy_d = ~buf_full_d;
  end

  // State registers with asynchronous reset to the idle frame state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= {DIV_W{1'b0}};
      sclk_q       <= 1'b0;
      ws_q         <= 1'b1;
      data_q       <= 1'b0;
      bcnt_q       <= {BCNT_W{1'b0}};
      buf_full_q   <= 1'b0;
      buf_l_q      <= {WIDTH{1'b0}};
      buf_r_q      <= {WIDTH{1'b0}};
      sh_l_q       <= {WIDTH{1'b0}};
      sh_r_q       <= {WIDTH{1'b0}};
      smpl_rdy_q   <= 1'b1;
      frame_strt_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef I2S_TX_REPEAT_EN
      last_l_q     <= {WIDTH{1'b0}};
      last_r_q     <= {WIDTH{1'b0}};
`endif
    end else begin
      div_q        <= div_d;
      sclk_q       <= sclk_d;
      ws_q         <= ws_d;
      data_q       <= data_d;
      bcnt_q       <= bcnt_d;
      buf_full_q   <= buf_full_d;
      buf_l_q      <= buf_l_d;
      buf_r_q      <= buf_r_d;
      sh_l_q       <= sh_l_d;
      sh_r_q       <= sh_r_d;
      smpl_rdy_q   <= smpl_rdy_d;
      frame_strt_q <= frame_strt_d;
      underrun_q   <= underrun_d;
`ifdef I2S_TX_REPEAT_EN
      last_l_q     <= last_l_d;
      last_r_q     <= last_r_d;
`endif
    end
  end

  assign smpl_rdy   = smpl_rdy_q;
  assign I2S_sclk   = sclk_q;
  assign I2S_ws     = ws_q;
  assign I2S_data   = data_q;
  assign frame_strt = frame_strt_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_master
//   Directed bench for i2s_tx_master at default parameters. Stimulus pushes
//   the pair each frame is expected to carry into a scoreboard queue. A
//   monitor acts as an I2S receiver: it captures data on sclk rising edges
//   and pops and compares one pair per received frame. It also checks slot
//   lengths and zero padding. Timing, handshake and pulse checks are done
//   at known clk counts after reset release.
// ---------------------------------------------------------------------------
module tb_i2s_tx_master;

  localparam int WIDTH     = 24;
  localparam int SLOT_BITS = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] lft_smpl = {WIDTH{1'b0}};
  logic [WIDTH-1:0] rght_smpl = {WIDTH{1'b0}};
  logic             smpl_vld = 1'b0;
  logic             smpl_rdy;
  logic             I2S_sclk;
  logic             I2S_ws;
  logic             I2S_data;
  logic             frame_strt;
  logic             underrun;

  always #10 clk = ~clk;

  i2s_tx_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .smpl_vld   (smpl_vld),
    .smpl_rdy   (smpl_rdy),
    .I2S_sclk   (I2S_sclk),
    .I2S_ws     (I2S_ws),
    .I2S_data   (I2S_data),
    .frame_strt (frame_strt),
    .underrun   (underrun)
  );

  typedef struct packed {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } pair_t;

  pair_t sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc;
  int    fs_cnt;
  int    uf_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // clk count since reset release: at negedge k, cyc == k
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pulse counters, cleared by reset
  always @(negedge clk) begin
    if (!rst_n) begin
      fs_cnt <= 0;
      uf_cnt <= 0;
    end else begin
      if (frame_strt) fs_cnt <= fs_cnt + 1;
      if (underrun)   uf_cnt <= uf_cnt + 1;
    end
  end

  // Receiver-style monitor: capture on sclk rise, compare per frame
  logic             prev_sclk, prev_ws, synced, ch, pad_bad;
  int               pos;
  logic [WIDTH-1:0] cap_l, cap_r;
  pair_t            exp_p;

  initial begin
    prev_sclk = 1'b0; prev_ws = 1'b1; synced = 1'b0; ch = 1'b0;
    pad_bad = 1'b0; pos = 0; cap_l = {WIDTH{1'b0}}; cap_r = {WIDTH{1'b0}};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sclk = 1'b0; prev_ws = 1'b1; synced = 1'b0;
      end else begin
        if (I2S_sclk && !prev_sclk) begin
          if (!synced) begin
            if (!I2S_ws && prev_ws) begin
              synced = 1'b1; ch = 1'b0; pos = 0; pad_bad = I2S_data;
              cap_l = {WIDTH{1'b0}}; cap_r = {WIDTH{1'b0}};
            end
          end else if (I2S_ws != prev_ws) begin
            chk("slot_len", pos, SLOT_BITS - 1);
            ch  = I2S_ws;
            pos = 0;
            if (!I2S_ws) begin
              pad_bad = 1'b0; cap_l = {WIDTH{1'b0}}; cap_r = {WIDTH{1'b0}};
            end
            pad_bad = pad_bad | I2S_data;
          end else begin
            pos++;
            if (pos >= 1 && pos <= WIDTH) begin
              if (ch) cap_r = {cap_r[WIDTH-2:0], I2S_data};
              else    cap_l = {cap_l[WIDTH-2:0], I2S_data};
            end else begin
              pad_bad = pad_bad | I2S_data;
            end
            if (ch && pos == SLOT_BITS - 1) begin
              if (sb_q.size() == 0) begin
                chk("frame_unexpected", 32'd1, 32'd0);
              end else begin
                exp_p = sb_q.pop_front();
                chk("frame_lft", cap_l, exp_p.l);
                chk("frame_rght", cap_r, exp_p.r);
                chk("frame_pad", pad_bad, 1'b0);
              end
            end
          end
          prev_ws = I2S_ws;
        end
        prev_sclk = I2S_sclk;
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Reset for 3 clk, checking every output holds its reset value.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    smpl_vld = 1'b0;
    lft_smpl = {WIDTH{1'b0}};
    rght_smpl = {WIDTH{1'b0}};
    sb_q.delete();
    @(negedge clk);
    chk("rst_sclk", I2S_sclk, 1'b0);
    chk("rst_ws", I2S_ws, 1'b1);
    chk("rst_data", I2S_data, 1'b0);
    chk("rst_rdy", smpl_rdy, 1'b1);
    chk("rst_fs", frame_strt, 1'b0);
    chk("rst_uf", underrun, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one pair, wait (bounded) for the handshake, then drop valid.
  task automatic send(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    int n;
    n = 0;
    lft_smpl = l;
    rght_smpl = r;
    smpl_vld = 1'b1;
    while (smpl_rdy !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    smpl_vld = 1'b0;
  endtask

  function automatic pair_t mk(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    return p;
  endfunction

  initial begin
    pair_t rp;

    // Continuous valid with A5A5A5 / 5A5A5A
    do_reset();
    lft_smpl = 24'hA5A5A5; rght_smpl = 24'h5A5A5A; smpl_vld = 1'b1;
    for (int i = 0; i < 3; i++) sb_q.push_back(mk(24'hA5A5A5, 24'h5A5A5A));
    goto(1);    chk("t1_rdy_drop", smpl_rdy, 1'b0);
    goto(15);   chk("t1_sclk_lo", I2S_sclk, 1'b0);
    goto(16);   chk("t1_sclk_rise", I2S_sclk, 1'b1);
    goto(31);   chk("t1_ws_pre", I2S_ws, 1'b1);
    goto(32);   chk("t1_ws_fall", I2S_ws, 1'b0);
                chk("t1_sclk_fall", I2S_sclk, 1'b0);
                chk("t1_fs", frame_strt, 1'b1);
                chk("t1_uf", underrun, 1'b0);
                chk("t1_delay_bit", I2S_data, 1'b0);
    goto(64);   chk("t1_msb", I2S_data, 1'b1);
    goto(1055); chk("t1_ws_lo_end", I2S_ws, 1'b0);
    goto(1056); chk("t1_ws_rise", I2S_ws, 1'b1);
    goto(6170);
    chk("t1_drain", sb_q.size(), 0);
    chk("t1_uf_cnt", uf_cnt, 0);
    chk("t1_fs_cnt", fs_cnt, 3);

    // No valid after reset: one underrun per frame, zero data
    do_reset();
    for (int i = 0; i < 3; i++) sb_q.push_back(mk(24'h000000, 24'h000000));
    goto(31);   chk("t2_uf_pre", underrun, 1'b0);
    goto(32);   chk("t2_uf", underrun, 1'b1);
                chk("t2_fs", frame_strt, 1'b1);
    goto(33);   chk("t2_uf_post", underrun, 1'b0);
    goto(6170);
    chk("t2_drain", sb_q.size(), 0);
    chk("t2_uf_cnt", uf_cnt, 3);
    chk("t2_fs_cnt", fs_cnt, 3);

    // Back-to-back P1, P2, then nothing
    do_reset();
    sb_q.push_back(mk(24'h800001, 24'h7FFFFE));
    sb_q.push_back(mk(24'hFFFFFF, 24'h000001));
    sb_q.push_back(mk(24'h000000, 24'h000000));
    lft_smpl = 24'h800001; rght_smpl = 24'h7FFFFE; smpl_vld = 1'b1;
    goto(1);
    chk("t3_rdy_p1", smpl_rdy, 1'b0);
    lft_smpl = 24'hFFFFFF; rght_smpl = 24'h000001;
    goto(31);   chk("t3_rdy_hold", smpl_rdy, 1'b0);
    goto(32);   chk("t3_rdy_rise", smpl_rdy, 1'b1);
    goto(33);   chk("t3_rdy_p2", smpl_rdy, 1'b0);
    smpl_vld = 1'b0;
    goto(6170);
    chk("t3_drain", sb_q.size(), 0);
    chk("t3_uf_cnt", uf_cnt, 1);

    // Valid first asserted in the load cycle: bypass
    do_reset();
    sb_q.push_back(mk(24'hDEADBE, 24'h0BEEF0));
    sb_q.push_back(mk(24'h000000, 24'h000000));
    sb_q.push_back(mk(24'h000000, 24'h000000));
    goto(31);
    lft_smpl = 24'hDEADBE; rght_smpl = 24'h0BEEF0; smpl_vld = 1'b1;
    goto(32);
    smpl_vld = 1'b0;
    chk("t4_uf", underrun, 1'b0);
    chk("t4_fs", frame_strt, 1'b1);
    chk("t4_rdy", smpl_rdy, 1'b1);
    goto(6170);
    chk("t4_drain", sb_q.size(), 0);
    chk("t4_uf_cnt", uf_cnt, 2);

    // Reset at bcnt = 40; the interrupted frame is dropped
    do_reset();
    send(24'h0F0F0F, 24'hF0F0F0);
    goto(1289);
    do_reset();
    sb_q.push_back(mk(24'h000000, 24'h000000));
    goto(31);   chk("t5_ws_pre", I2S_ws, 1'b1);
                chk("t5_sclk_hi", I2S_sclk, 1'b1);
    goto(32);   chk("t5_ws_fall", I2S_ws, 1'b0);
                chk("t5_sclk_fall", I2S_sclk, 1'b0);
                chk("t5_fs", frame_strt, 1'b1);
                chk("t5_uf", underrun, 1'b1);
    goto(2100);
    chk("t5_drain", sb_q.size(), 0);

    // Random pairs streamed through the handshake
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rp.l = WIDTH'($urandom());
      rp.r = WIDTH'($urandom());
      sb_q.push_back(rp);
      send(rp.l, rp.r);
    end
    goto(8215);
    chk("t6_drain", sb_q.size(), 0);
    chk("t6_uf_cnt", uf_cnt, 0);
    chk("t6_fs_cnt", fs_cnt, 4);

`ifdef I2S_TX_REPEAT_EN
    // Single pair then starvation: the pair repeats every frame
    do_reset();
    for (int i = 0; i < 3; i++) sb_q.push_back(mk(24'h123456, 24'hFEDCBA));
    send(24'h123456, 24'hFEDCBA);
    goto(6170);
    chk("t7_drain", sb_q.size(), 0);
    chk("t7_uf_cnt", uf_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- I2S transmitter (clock master): the opposite end of the I2S_Serf receiver.
- Accepts parallel 24-bit left/right sample pairs over a valid/ready handshake.
- Generates I2S_sclk, I2S_ws and I2S_data from the 50MHz system clock.
- Uses: bench stimulus source for the equalizer I2S input, and a loopback path from the EQ output to an external DAC.

Parameters:
- SCLK_DIV, 16: clk cycles per sclk half-period; sclk period = 2*SCLK_DIV clk.
- WIDTH, 24: sample bits per channel, sent MSB first.
- SLOT_BITS, 32: sclk periods per channel slot; must be >= WIDTH+1 (elaboration check).

Ports:
- clk  in  1  system clock, 50MHz
- rst_n  in  1  reset, asynchronous, active-low
- lft_smpl  in  WIDTH  left sample, two's complement
- rght_smpl  in  WIDTH  right sample, two's complement
- smpl_vld  in  1  sample pair valid
- smpl_rdy  out  1  holding buffer empty; pair accepted when smpl_vld&smpl_rdy
- I2S_sclk  out  1  bit clock
- I2S_ws  out  1  word select; 0 = left, 1 = right
- I2S_data  out  1  serial data; changes on sclk fall, receiver samples on rise
- frame_strt  out  1  one-clk pulse at each frame load
- underrun  out  1  one-clk pulse when a frame loads with the buffer empty

Behaviour:
- Reset values (all outputs registered): I2S_sclk=0, I2S_ws=1, I2S_data=0, smpl_rdy=1, frame_strt=0, underrun=0. Internal state also clears: div counter=0, bcnt=0, buffer empty, shift regs=0.
- Sclk gen: div counter 0..SCLK_DIV-1; sclk toggles on wrap.
- Fall tick = the clk cycle in which sclk toggles 1->0. First rise after SCLK_DIV clk; first fall tick after 2*SCLK_DIV clk.
- Bit counter bcnt 0..2*SLOT_BITS-1 advances on each fall tick and wraps to 0.
- Slot position p = bcnt mod SLOT_BITS; slot = left when bcnt < SLOT_BITS.
- On each fall tick, I2S_ws <= (bcnt >= SLOT_BITS). The ws edge therefore coincides with p=0.
- I2S_data at a fall tick (one-bit I2S delay):
  - p=0: 0 (padding of the previous slot).
  - p=1..WIDTH: bit WIDTH-p of the current channel's shift register.
  - p > WIDTH: 0.
- Frame load, on the fall tick with bcnt=0:
  - Buffer full: copy buffer into left/right shift regs, mark buffer empty, pulse frame_strt.
  - Buffer empty and smpl_vld=1 in that cycle: inputs bypass straight into the shift regs and the pair counts as accepted; no underrun; smpl_rdy stays 1.
  - Buffer empty and smpl_vld=0: shift regs load 0, pulse underrun and frame_strt.
- Handshake:
  - Accept on the clk edge where smpl_vld&smpl_rdy; smpl_rdy drops the next cycle.
  - smpl_rdy rises the cycle after a frame load empties the buffer.
  - Inputs are ignored while smpl_rdy=0.
- Latency: a pair accepted in a frame is transmitted in the next frame. Its left MSB appears on the fall tick with bcnt=1, i.e. 2*SCLK_DIV clk after the load tick.
- Timing at defaults: frame = 2*SLOT_BITS*2*SCLK_DIV = 2048 clk, giving ~24.4kHz fs.
- Async reset mid-frame: all state returns to reset values immediately. The next frame starts cleanly at bcnt=0. No partial word is resumed.
- Sample values: no arithmetic on the data; bits are shifted verbatim, sign preserved.

Optional Feature:
- Macro I2S_TX_REPEAT_EN.
- When defined: on underrun the shift regs reload the last transmitted pair (held in a last-pair register, reset 0). The underrun pulse is still asserted.
- When not defined: underrun frames transmit zeros, as above. The last-pair register is not built.

Test Plan:
- Default params; hold smpl_vld=1 with lft=24'hA5A5A5, rght=24'h5A5A5A. -> Sclk period is 32 clk. ws is low for 32 sclk then high for 32. Left MSB (1) is driven one sclk after the ws fall. Rising-edge capture yields A5A5A5 and 5A5A5A, with p=25..31 bits 0.
- No smpl_vld after reset. -> Exactly one underrun+frame_strt pulse per 2048 clk; I2S_data stays 0.
- With I2S_TX_REPEAT_EN: send one pair 24'h123456/24'hFEDCBA, then stop. -> Following frames repeat the same values and underrun pulses each frame.
- Offer pairs P1 then P2 back-to-back. -> P1 is accepted and smpl_rdy=0 until the next load. P2 is accepted the cycle after smpl_rdy rises. P1 and P2 are transmitted in consecutive frames, with no underrun.
- smpl_vld first rises in the exact load cycle with the buffer empty. -> Bypass: that pair goes out in the current frame with no underrun pulse.
- Assert rst_n low at bcnt=40 for 3 clk. -> All outputs equal reset values during reset. After release the first fall tick is at 2*SCLK_DIV clk, with bcnt=0 and ws going low.
- Loopback into I2S_Serf with random pairs. -> Its vld pulses once per frame, and lft_chnnl/rght_chnnl match the transmitted pairs one frame later.
